maze_game_ctrl: RTL and testbench

//  Game sequencer for the maze levels. Owns the player square: position, movement from buttons,

---
 rtl/maze_pkg.sv | 18 +
 rtl/maze_frame_sync.sv | 35 +++
 rtl/maze_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared state encoding and screen geometry for the maze game controller.
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    WIN  = 3'd3,
    DONE = 3'd4,
    OVER = 3'd5
  } game_state_t;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int START_X = 117;
  localparam int START_Y = 447;

endpackage

// File: rtl/maze_frame_sync.sv
// Frame tick: a registered one-cycle pulse when the scan arrives at (0,0)
// from any other position, so a scan parked at the origin yields one pulse.
module maze_frame_sync
  import maze_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [9:0] col,
  input  logic [8:0] row,
  output logic       tick
);

  logic at_origin;
  logic armed_q, armed_d;
  logic tick_q, tick_d;

  always_comb begin
    at_origin = (col == 10'd0) && (row == 9'd0);
    armed_d   = ~at_origin;
    tick_d    = at_origin & armed_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: player position and movement, per-frame wall/finish
// detection against the renderer's pixel flags, lives and level selection.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int PLAYER_SIZE = 16,
  parameter int STEP        = 2,
  parameter int MOVE_DIV    = 2,
  parameter int HIT_FRAMES  = 30,
  parameter int WIN_FRAMES  = 60,
  parameter int NUM_LEVELS  = 3,
  parameter int LIVES       = 3
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  input  logic [9:0] col,
  input  logic [8:0] row,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       path_px,
  input  logic       finish_px,
  output logic       player_px,
  output logic [9:0] player_x,
  output logic [8:0] player_y,
  output logic [1:0] level_sel,
  output logic [2:0] game_state,
  output logic [1:0] lives_left
);

  game_state_t state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic        player_px_q, player_px_d;
  logic        hit_acc_q, hit_acc_d;
  logic        fin_acc_q, fin_acc_d;
  logic [7:0]  move_cnt_q, move_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        tick;
  logic        move_tick;
  logic [9:0]  dx;
  logic [8:0]  dy;

  maze_frame_sync u_frame_sync (
    .pixel_clk (pixel_clk),
    .rst       (resetSwitch),
    .col       (col),
    .row       (row),
    .tick      (tick)
  );

  function automatic logic [9:0] clamp_x(input int v);
    if (v < 0) return 10'd0;
    if (v > H_RES - PLAYER_SIZE) return 10'(H_RES - PLAYER_SIZE);
    return 10'(v);
  endfunction

  function automatic logic [8:0] clamp_y(input int v);
    if (v < 0) return 9'd0;
    if (v > V_RES - PLAYER_SIZE) return 9'(V_RES - PLAYER_SIZE);
    return 9'(v);
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    level_d     = level_q;
    lives_d     = lives_q;
    move_cnt_d  = move_cnt_q;
    frame_cnt_d = frame_cnt_q;
    move_tick   = 1'b0;

    // Unsigned wrap makes pixels left of / above the square compare large.
    dx          = col - x_q;
    dy          = row - y_q;
    player_px_d = (dx < 10'(PLAYER_SIZE)) && (dy < 9'(PLAYER_SIZE));

    // The tick cycle already carries the new frame's first pixel flags.
    if (tick) begin
      hit_acc_d = player_px_q & ~path_px;
      fin_acc_d = player_px_q & finish_px;
    end else begin
      hit_acc_d = hit_acc_q | (player_px_q & ~path_px);
      fin_acc_d = fin_acc_q | (player_px_q & finish_px);
    end

    if (tick) begin
      if (move_cnt_q == 8'(MOVE_DIV - 1)) begin
        move_cnt_d = 8'd0;
        move_tick  = 1'b1;
      end else begin
        move_cnt_d = move_cnt_q + 8'd1;
      end

      case (state_q)
        IDLE: if (btn_up | btn_down | btn_left | btn_right) state_d = PLAY;
        PLAY: begin
          if (hit_acc_q) begin
            state_d     = HIT;
            lives_d     = lives_q - 2'd1;
            frame_cnt_d = 8'd0;
          end else if (fin_acc_q) begin
            state_d     = WIN;
            frame_cnt_d = 8'd0;
          end else if (move_tick) begin
            if (btn_up)         y_d = clamp_y(int'(y_q) - STEP);
            else if (btn_down)  y_d = clamp_y(int'(y_q) + STEP);
            else if (btn_left)  x_d = clamp_x(int'(x_q) - STEP);
            else if (btn_right) x_d = clamp_x(int'(x_q) + STEP);
          end
        end
        HIT: begin
          if (frame_cnt_q == 8'(HIT_FRAMES - 1)) begin
            frame_cnt_d = 8'd0;
            x_d         = 10'(START_X);
            y_d         = 9'(START_Y);
            state_d     = (lives_q == 2'd0) ? OVER : PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        WIN: begin
          if (frame_cnt_q == 8'(WIN_FRAMES - 1)) begin
            frame_cnt_d = 8'd0;
            if (level_q == 2'(NUM_LEVELS - 1)) begin
              state_d = DONE;
            end else begin
              level_d = level_q + 2'd1;
              x_d     = 10'(START_X);
              y_d     = 9'(START_Y);
              state_d = PLAY;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (resetSwitch) begin
      state_q     <= IDLE;
      x_q         <= 10'(START_X);
      y_q         <= 9'(START_Y);
      level_q     <= 2'd0;
      lives_q     <= 2'(LIVES);
      player_px_q <= 1'b0;
      hit_acc_q   <= 1'b0;
      fin_acc_q   <= 1'b0;
      move_cnt_q  <= 8'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      player_px_q <= player_px_d;
      hit_acc_q   <= hit_acc_d;
      fin_acc_q   <= fin_acc_d;
      move_cnt_q  <= move_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign player_px  = player_px_q;
  assign player_x   = x_q;
  assign player_y   = y_q;
  assign level_sel  = level_q;
  assign game_state = state_q;
  assign lives_left = lives_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl: sparse per-frame scans checked against a
// frame-level reference model of the game rules.
module tb_maze_game_ctrl;
  import maze_pkg::*;

  localparam int PLAYER_SIZE = 16;
  localparam int STEP        = 2;
  localparam int MOVE_DIV    = 2;
  localparam int HIT_FRAMES  = 30;
  localparam int WIN_FRAMES  = 60;
  localparam int NUM_LEVELS  = 3;
  localparam int LIVES       = 3;

  logic       pixel_clk = 1'b0;
  logic       resetSwitch;
  logic [9:0] col;
  logic [8:0] row;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       path_px, finish_px;
  logic       player_px;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic [1:0] level_sel;
  logic [2:0] game_state;
  logic [1:0] lives_left;

  always #5 pixel_clk = ~pixel_clk;

  maze_game_ctrl dut (
    .pixel_clk   (pixel_clk),
    .resetSwitch (resetSwitch),
    .col         (col),
    .row         (row),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .path_px     (path_px),
    .finish_px   (finish_px),
    .player_px   (player_px),
    .player_x    (player_x),
    .player_y    (player_y),
    .level_sel   (level_sel),
    .game_state  (game_state),
    .lives_left  (lives_left)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: game status at frame granularity.
  int m_state, m_px, m_py, m_level, m_lives, m_cnt, m_ticks;
  bit cur_path, cur_fin, prev_path, prev_fin;
  bit pend_vld, pend_exp;
  int saved_x, saved_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = int'(IDLE); m_px = START_X; m_py = START_Y;
    m_level = 0; m_lives = LIVES; m_cnt = 0; m_ticks = 0;
    cur_path = 1'b1; cur_fin = 1'b0; prev_path = 1'b1; prev_fin = 1'b0;
    pend_vld = 1'b0; pend_exp = 1'b0;
  endtask

  task automatic model_tick();
    bit mv;
    m_ticks++;
    mv = (m_ticks % MOVE_DIV) == 0;
    if (m_state == int'(IDLE)) begin
      if (btn_up || btn_down || btn_left || btn_right) m_state = int'(PLAY);
    end else if (m_state == int'(PLAY)) begin
      if (!prev_path) begin
        m_state = int'(HIT); m_lives--; m_cnt = 0;
      end else if (prev_fin) begin
        m_state = int'(WIN); m_cnt = 0;
      end else if (mv) begin
        if (btn_up)         m_py = (m_py >= STEP) ? m_py - STEP : 0;
        else if (btn_down)  m_py = (m_py + STEP <= V_RES - PLAYER_SIZE) ? m_py + STEP : V_RES - PLAYER_SIZE;
        else if (btn_left)  m_px = (m_px >= STEP) ? m_px - STEP : 0;
        else if (btn_right) m_px = (m_px + STEP <= H_RES - PLAYER_SIZE) ? m_px + STEP : H_RES - PLAYER_SIZE;
      end
    end else if (m_state == int'(HIT)) begin
      m_cnt++;
      if (m_cnt == HIT_FRAMES) begin
        m_px = START_X; m_py = START_Y;
        m_state = (m_lives == 0) ? int'(OVER) : int'(PLAY);
      end
    end else if (m_state == int'(WIN)) begin
      m_cnt++;
      if (m_cnt == WIN_FRAMES) begin
        if (m_level == NUM_LEVELS - 1) begin
          m_state = int'(DONE);
        end else begin
          m_level++; m_px = START_X; m_py = START_Y; m_state = int'(PLAY);
        end
      end
    end
  endtask

  task automatic drive(input int c, input int r);
    col = 10'(c); row = 9'(r); path_px = cur_path; finish_px = cur_fin;
  endtask

  task automatic pix(input int c, input int r, input bit vld, input bit exp_in);
    @(negedge pixel_clk);
    if (pend_vld) chk("player_px", {31'd0, player_px}, {31'd0, pend_exp});
    pend_vld = vld; pend_exp = exp_in;
    drive(c, r);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, 32'(game_state), 32'(m_state));
    chk({tag, ".x"},     32'(player_x),   32'(m_px));
    chk({tag, ".y"},     32'(player_y),   32'(m_py));
    chk({tag, ".level"}, 32'(level_sel),  32'(m_level));
    chk({tag, ".lives"}, 32'(lives_left), 32'(m_lives));
  endtask

  task automatic check_reset(input string tag);
    model_reset();
    chk({tag, ".state"}, 32'(game_state), 32'(IDLE));
    chk({tag, ".x"},     32'(player_x),   32'd117);
    chk({tag, ".y"},     32'(player_y),   32'd447);
    chk({tag, ".level"}, 32'(level_sel),  32'd0);
    chk({tag, ".lives"}, 32'(lives_left), 32'd3);
    chk({tag, ".ppx"},   32'(player_px),  32'd0);
  endtask

  // One frame: origin, a spacer pixel during the tick, two pixels inside the
  // player and two outside; path/finish flags are constant for the frame.
  task automatic frame(input bit p, input bit f, input bit [3:0] b);
    int ox;
    prev_path = cur_path; prev_fin = cur_fin;
    cur_path = p; cur_fin = f;
    {btn_up, btn_down, btn_left, btn_right} = b;
    pix(0, 0, 1'b0, 1'b0);
    pix(1, 0, 1'b0, 1'b0);
    model_tick();
    @(negedge pixel_clk);
    check_outputs("tick");
    ox = (m_px + PLAYER_SIZE < H_RES) ? m_px + PLAYER_SIZE : m_px - 1;
    drive(m_px, m_py);
    pend_vld = 1'b1; pend_exp = 1'b1;
    pix(m_px + PLAYER_SIZE - 1, m_py + PLAYER_SIZE - 1, 1'b1, 1'b1);
    pix(ox, m_py, 1'b1, 1'b0);
    pix(m_px, m_py + PLAYER_SIZE, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge pixel_clk);
    resetSwitch = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    cur_path = 1'b1; cur_fin = 1'b0;
    drive(5, 5);
    @(negedge pixel_clk);
    check_reset(tag);
    resetSwitch = 1'b0;
  endtask

  initial begin
    resetSwitch = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    model_reset();
    drive(5, 5);
    repeat (3) @(negedge pixel_clk);
    check_reset("rst0");
    resetSwitch = 1'b0;

    // Start and first move
    frame(1'b1, 1'b0, 4'b0001);
    chk("t1.state", 32'(game_state), 32'(PLAY));
    chk("t1.x_hold", 32'(player_x), 32'd117);
    frame(1'b1, 1'b0, 4'b0001);
    chk("t1.x_move", 32'(player_x), 32'd119);
    chk("t1.y", 32'(player_y), 32'd447);
    frame(1'b1, 1'b0, 4'b0000);

    // Wall hit, freeze, respawn
    frame(1'b0, 1'b0, 4'b0000);
    frame(1'b1, 1'b0, 4'b0000);
    chk("t2.state_hit", 32'(game_state), 32'(HIT));
    chk("t2.lives", 32'(lives_left), 32'd2);
    repeat (HIT_FRAMES - 1) frame(1'b1, 1'b0, 4'b0001);
    chk("t2.still_hit", 32'(game_state), 32'(HIT));
    frame(1'b1, 1'b0, 4'b0000);
    chk("t2.respawn_state", 32'(game_state), 32'(PLAY));
    chk("t2.respawn_x", 32'(player_x), 32'd117);
    chk("t2.respawn_y", 32'(player_y), 32'd447);

    // Random wandering on an open level
    repeat (40) frame(1'b1, 1'b0, 4'($urandom_range(0, 15)));

    // Clamp at the left and bottom edges
    for (int i = 0; i < 800 && m_px != 0; i++) frame(1'b1, 1'b0, 4'b0010);
    repeat (10) begin
      frame(1'b1, 1'b0, 4'b0010);
      chk("t5.x_clamp", 32'(player_x), 32'd0);
    end
    for (int i = 0; i < 800 && m_py != V_RES - PLAYER_SIZE; i++) frame(1'b1, 1'b0, 4'b0100);
    repeat (10) begin
      frame(1'b1, 1'b0, 4'b0100);
      chk("t5.y_clamp", 32'(player_y), 32'd464);
    end

    // Hit beats finish in the same frame
    frame(1'b0, 1'b1, 4'b0000);
    frame(1'b1, 1'b0, 4'b0000);
    chk("t6.hit_not_win", 32'(game_state), 32'(HIT));
    chk("t6.lives", 32'(lives_left), 32'd1);
    repeat (HIT_FRAMES) frame(1'b1, 1'b0, 4'b0000);
    chk("t6.back_play", 32'(game_state), 32'(PLAY));

    // Three finishes: levels 1, 2, then done
    for (int lv = 0; lv < NUM_LEVELS; lv++) begin
      frame(1'b1, 1'b1, 4'b0000);
      frame(1'b1, 1'b0, 4'b0000);
      chk("t4.win", 32'(game_state), 32'(WIN));
      repeat (WIN_FRAMES) frame(1'b1, 1'b0, 4'b0000);
      if (lv < NUM_LEVELS - 1) begin
        chk("t4.level", 32'(level_sel), 32'(lv + 1));
        chk("t4.play", 32'(game_state), 32'(PLAY));
        chk("t4.respawn_x", 32'(player_x), 32'd117);
      end
    end
    chk("t4.done", 32'(game_state), 32'(DONE));
    chk("t4.level2", 32'(level_sel), 32'd2);
    repeat (6) frame(1'b1, 1'b0, 4'($urandom_range(1, 15)));
    chk("t4.done_hold", 32'(game_state), 32'(DONE));

    // Game over after three hits
    do_reset("rst1");
    frame(1'b1, 1'b0, 4'b1000);
    for (int h = 0; h < 3; h++) begin
      frame(1'b0, 1'b0, 4'b0000);
      repeat (HIT_FRAMES + 1) frame(1'b1, 1'b0, 4'b0000);
    end
    chk("t3.over", 32'(game_state), 32'(OVER));
    chk("t3.lives0", 32'(lives_left), 32'd0);
    saved_x = m_px; saved_y = m_py;
    repeat (6) frame(1'b1, 1'b0, 4'($urandom_range(1, 15)));
    chk("t3.frozen_x", 32'(player_x), 32'(saved_x));
    chk("t3.frozen_y", 32'(player_y), 32'(saved_y));
    chk("t3.over_hold", 32'(game_state), 32'(OVER));
    do_reset("rst2");

    // Reset in the middle of a frame while playing
    frame(1'b1, 1'b0, 4'b1000);
    repeat (4) frame(1'b1, 1'b0, 4'b1000);
    prev_path = cur_path; prev_fin = cur_fin;
    pix(0, 0, 1'b0, 1'b0);
    pix(1, 0, 1'b0, 1'b0);
    model_tick();
    @(negedge pixel_clk);
    check_outputs("mid");
    drive(m_px, m_py);
    @(negedge pixel_clk);
    chk("mid.player_px", 32'(player_px), 32'd1);
    resetSwitch = 1'b1;
    drive(m_px + 1, m_py + 1);
    @(negedge pixel_clk);
    check_reset("mid_rst");
    resetSwitch = 1'b0;
    drive(5, 5);
    frame(1'b1, 1'b0, 4'b0100);
    chk("post_rst.play", 32'(game_state), 32'(PLAY));
    frame(1'b1, 1'b0, 4'b0100);
    chk("post_rst.y", 32'(player_y), 32'd449);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
